// File: rtl/ro_worker_host.sv
`default_nettype none
// ==========================================================================
// ro_worker_host - host sequencer for a ring-oscillator worker: reset, operand
// load, optional free-run stop, done wait with timeout, two-byte readback. rev 1.0
// ==========================================================================
module ro_worker_host #(
   parameter int PULSE_CYCLES = 8,
   parameter int RST_CYCLES   = 4,
   parameter int TIMEOUT      = 65535
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        mode_in,
   input  logic [15:0] op_a,
   input  logic [15:0] op_b,
   input  logic [15:0] stop_after,
   input  logic        clock_sel_in,
   output logic [7:0]  w_din,
   output logic        w_shift,
   output logic        w_stop,
   output logic        w_mode,
   output logic        w_clock_sel,
   output logic        w_rst_n,
   input  logic [7:0]  w_dout,
   input  logic        w_done,
   output logic        busy,
   output logic        valid,
   output logic [15:0] result,
   output logic        timeout_err
);

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_WRST      = 4'd1;
   localparam logic [3:0] S_LOAD_LO   = 4'd2;
   localparam logic [3:0] S_LOAD_HI   = 4'd3;
   localparam logic [3:0] S_RUN       = 4'd4;
   localparam logic [3:0] S_STOP_HI   = 4'd5;
   localparam logic [3:0] S_STOP_LO   = 4'd6;
   localparam logic [3:0] S_WAIT      = 4'd7;
   localparam logic [3:0] S_RD_SETTLE = 4'd8;
   localparam logic [3:0] S_RD_HI     = 4'd9;
   localparam logic [3:0] S_RD_LO     = 4'd10;
   localparam logic [3:0] S_FINISH    = 4'd11;

   localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYCLES - 1);
   localparam logic [15:0] RST_LAST   = 16'(RST_CYCLES - 1);

   logic [3:0]  state, state_nxt;
   logic [15:0] cnt, tmr, a_q, b_q, stop_q;
   logic        mode_q, csel_q, done_s1, done_s2;
   logic [1:0]  slot, slot_d;
   logic        phase_end, timed, tmr_limit, timeout_hit;
   logic [7:0]  din_d;
   logic        shift_d, stop_d, wrst_d, mode_d, csel_d, busy_d, valid_d;

   assign phase_end = (cnt == PULSE_LAST);
   assign timed     = (state == S_RUN) || (state == S_STOP_HI) ||
                      (state == S_STOP_LO) || (state == S_WAIT);
   assign tmr_limit = (({1'b0, tmr} + 17'd1) >= 17'(TIMEOUT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      timeout_hit = 1'b0;
      case (state)
         S_IDLE:      if (start) state_nxt = S_WRST;
         S_WRST:      if (cnt == RST_LAST) state_nxt = S_LOAD_LO;
         S_LOAD_LO:   if (phase_end) state_nxt = S_LOAD_HI;
         S_LOAD_HI: begin
            if (phase_end) begin
               if (slot != 2'd3)        state_nxt = S_LOAD_LO;
               else if (!mode_q)        state_nxt = S_WAIT;
               else if (stop_q == 16'd0) state_nxt = S_STOP_HI;
               else                     state_nxt = S_RUN;
            end
         end
         S_RUN:       if (cnt == stop_q - 16'd1) state_nxt = S_STOP_HI;
         S_STOP_HI:   if (phase_end) state_nxt = S_STOP_LO;
         S_STOP_LO:   if (phase_end) state_nxt = S_WAIT;
         S_WAIT:      if (done_s2) state_nxt = S_RD_SETTLE;
         S_RD_SETTLE: if (phase_end) state_nxt = S_RD_HI;
         S_RD_HI:     if (phase_end) state_nxt = S_RD_LO;
         S_RD_LO:     if (phase_end) state_nxt = S_FINISH;
         S_FINISH:    state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
      // A done seen in the same cycle as the limit still wins the readback.
      if (timed && tmr_limit && !(state == S_WAIT && done_s2)) begin
         state_nxt   = S_FINISH;
         timeout_hit = 1'b1;
      end
   end

   // Outputs are decoded from the next state so the registered copies line up with it.
   always_comb begin
      din_d   = 8'h00;
      shift_d = 1'b0;
      stop_d  = 1'b0;
      wrst_d  = 1'b1;
      busy_d  = 1'b1;
      valid_d = 1'b0;
      mode_d  = 1'b0;
      csel_d  = 1'b0;
      slot_d  = slot;
      if (state == S_LOAD_HI && state_nxt == S_LOAD_LO) slot_d = slot + 2'd1;
      case (state_nxt)
         S_IDLE:    busy_d = 1'b0;
         S_WRST:    wrst_d = 1'b0;
         S_LOAD_LO, S_LOAD_HI: begin
            shift_d = (state_nxt == S_LOAD_HI);
            case (slot_d)
               2'd0:    din_d = a_q[15:8];
               2'd1:    din_d = a_q[7:0];
               2'd2:    din_d = b_q[15:8];
               default: din_d = b_q[7:0];
            endcase
         end
         S_STOP_HI: stop_d = 1'b1;
         S_RD_HI:   shift_d = 1'b1;
         S_FINISH: begin
            busy_d  = 1'b0;
            valid_d = 1'b1;
         end
         default: ;
      endcase
      if (state_nxt != S_IDLE && state_nxt != S_WRST) begin
         mode_d = mode_q;
         csel_d = csel_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_s1 <= 1'b0;  done_s2 <= 1'b0;
         cnt <= 16'd0;  tmr <= 16'd0;  slot <= 2'd0;
         a_q <= 16'd0;  b_q <= 16'd0;  stop_q <= 16'd0;
         mode_q <= 1'b0;  csel_q <= 1'b0;
         w_din <= 8'h00;  w_shift <= 1'b0;  w_stop <= 1'b0;
         w_mode <= 1'b0;  w_clock_sel <= 1'b0;  w_rst_n <= 1'b0;
         busy <= 1'b0;  valid <= 1'b0;  result <= 16'd0;  timeout_err <= 1'b0;
      end else begin
         done_s1 <= w_done;
         done_s2 <= done_s1;
         cnt     <= (state_nxt != state) ? 16'd0 : cnt + 16'd1;
         if (!timed || (state != S_WAIT && state_nxt == S_WAIT)) tmr <= 16'd0;
         else if (tmr != 16'hFFFF)                                tmr <= tmr + 16'd1;
         slot        <= slot_d;
         w_din       <= din_d;
         w_shift     <= shift_d;
         w_stop      <= stop_d;
         w_mode      <= mode_d;
         w_clock_sel <= csel_d;
         w_rst_n     <= wrst_d;
         busy        <= busy_d;
         valid       <= valid_d;
         if (state == S_IDLE && start) begin
            a_q <= op_a;  b_q <= op_b;  stop_q <= stop_after;
            mode_q <= mode_in;  csel_q <= clock_sel_in;
            slot <= 2'd0;
            timeout_err <= 1'b0;
         end
         if (timeout_hit) begin
            result      <= 16'd0;
            timeout_err <= 1'b1;
         end
         if (state == S_RD_SETTLE && state_nxt == S_RD_HI) result[15:8] <= w_dout;
         if (state == S_RD_LO && state_nxt == S_FINISH)    result[7:0]  <= w_dout;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ro_worker_host.sv
`default_nettype none
// tb_ro_worker_host - host sequencer paired with a cycle-level worker model,
// directed corner cases plus randomized transactions against a reference model.
module tb_ro_worker_host;

   localparam int PULSE = 8;
   localparam int TMO   = 100;

   logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, mode_in = 1'b0, clock_sel_in = 1'b0;
   logic [15:0] op_a = 16'd0, op_b = 16'd0, stop_after = 16'd0;
   logic [7:0]  w_din, w_dout;
   logic        w_shift, w_stop, w_mode, w_clock_sel, w_rst_n, w_done;
   logic        busy, valid, timeout_err;
   logic [15:0] result;
   int          n_tests = 0, n_fail = 0;
   bit          done_kill = 1'b0;

   ro_worker_host #(.PULSE_CYCLES(PULSE), .RST_CYCLES(4), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode_in(mode_in),
      .op_a(op_a), .op_b(op_b), .stop_after(stop_after), .clock_sel_in(clock_sel_in),
      .w_din(w_din), .w_shift(w_shift), .w_stop(w_stop), .w_mode(w_mode),
      .w_clock_sel(w_clock_sel), .w_rst_n(w_rst_n), .w_dout(w_dout), .w_done(w_done),
      .busy(busy), .valid(valid), .result(result), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // Worker: loads four bytes on w_shift rises; mode 0 computes A+B+1, mode 1
   // adds the number of clocks it free-ran until w_stop rose.
   logic [31:0] wk_ops;
   int          wk_n, wk_dly;
   logic        wk_ps, wk_pstop, wk_run, wk_done;
   logic [15:0] wk_cnt, wk_res;

   assign w_dout = wk_res[15:8];
   assign w_done = wk_done & ~done_kill;

   always @(posedge clk) begin
      if (!w_rst_n) begin
         wk_ops <= 0; wk_n <= 0; wk_dly <= 0; wk_ps <= 0; wk_pstop <= 0;
         wk_run <= 0; wk_done <= 0; wk_cnt <= 0; wk_res <= 0;
      end else begin
         wk_ps    <= w_shift;
         wk_pstop <= w_stop;
         if (wk_dly > 0) begin
            wk_dly <= wk_dly - 1;
            if (wk_dly == 1) wk_done <= 1'b1;
         end
         if (w_shift && !wk_ps) begin
            if (wk_n < 4) begin
               wk_ops <= {wk_ops[23:0], w_din};
               wk_n   <= wk_n + 1;
               if (wk_n == 3) begin
                  if (!w_mode) begin
                     wk_res <= wk_ops[23:8] + {wk_ops[7:0], w_din} + 16'd1;
                     wk_dly <= 3;
                  end else begin
                     wk_run <= 1'b1;
                     wk_cnt <= 16'd0;
                  end
               end
            end else if (wk_done) begin
               wk_res <= {wk_res[7:0], 8'h00};
            end
         end
         if (wk_run) begin
            if (w_stop && !wk_pstop) begin
               wk_run <= 1'b0;
               wk_res <= wk_ops[31:16] + wk_ops[15:0] + wk_cnt;
               wk_dly <= 3;
            end else begin
               wk_cnt <= wk_cnt + 16'd1;
            end
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic run_txn(input logic m, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] sa, input logic cs, input bit kill);
      logic [7:0]  dins [4] = '{default: 8'h00};
      int          shifts = 0, fall_cyc = -1, stop_start = -1, stop_len = 0, valid_cyc = -1;
      logic        ps = 1'b0, pstop = 1'b0;
      logic [15:0] exp_res, got_res = 16'd0;
      logic        got_to = 1'b0;
      if (kill)    exp_res = 16'd0;
      else if (!m) exp_res = a + b + 16'd1;
      else         exp_res = a + b + sa + 16'(PULSE - 1);
      done_kill = kill;
      @(negedge clk);
      mode_in = m; op_a = a; op_b = b; stop_after = sa; clock_sel_in = cs; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_eq("busy_after_start", 32'(busy), 32'd1);
      for (int cyc = 0; cyc < 1500 && valid_cyc < 0; cyc++) begin
         @(negedge clk);
         if (cyc == 10) begin start = 1'b1; op_a = ~a; op_b = ~b; end
         if (cyc == 11) begin start = 1'b0; op_a = a;  op_b = b;  end
         if (w_shift && !ps) begin
            if (shifts < 4) dins[shifts] = w_din;
            if (shifts == 0) check_eq("cfg_during_load", {30'd0, w_mode, w_clock_sel}, {30'd0, m, cs});
            shifts++;
         end
         if (!w_shift && ps && shifts == 4 && fall_cyc < 0) fall_cyc = cyc;
         if (w_stop && !pstop) stop_start = cyc;
         if (w_stop) stop_len++;
         if (valid) begin
            valid_cyc = cyc;
            got_res   = result;
            got_to    = timeout_err;
            check_eq("busy_at_valid", 32'(busy), 32'd0);
            check_eq("mode_at_finish", 32'(w_mode), 32'(m));
         end
         ps = w_shift;
         pstop = w_stop;
      end
      if (valid_cyc < 0) check_eq("valid_seen", 32'd0, 32'd1);
      check_eq("din_seq", {dins[0], dins[1], dins[2], dins[3]}, {a, b});
      check_eq("result", 32'(got_res), 32'(exp_res));
      check_eq("timeout_err", 32'(got_to), 32'(kill));
      check_eq("shift_rises", 32'(shifts), kill ? 32'd4 : 32'd5);
      if (m && !kill) begin
         check_eq("stop_delay", 32'(stop_start - fall_cyc), 32'(sa));
         check_eq("stop_len", 32'(stop_len), 32'(PULSE));
      end else begin
         check_eq("stop_len_none", 32'(stop_len), 32'd0);
      end
      if (kill && !m) check_eq("timeout_latency", 32'(valid_cyc - fall_cyc), 32'(TMO));
      @(negedge clk);
      check_eq("after_finish", {29'd0, valid, busy, w_mode}, 32'd0);
   endtask

   initial begin
      int          rises, vcount, guard;
      logic        ps_a;
      logic        m_r, cs_r;
      logic [15:0] a_r, b_r, sa_r;

      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("reset_outputs", {w_din, w_shift, w_stop, w_mode, w_clock_sel, w_rst_n,
                                 busy, valid, result, timeout_err}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("wrst_n_after_release", {30'd0, w_rst_n, busy}, 32'd2);

      run_txn(1'b0, 16'h1234, 16'h0010, 16'd0, 1'b0, 1'b0);
      run_txn(1'b0, 16'hFFFF, 16'h0000, 16'd0, 1'b1, 1'b0);
      run_txn(1'b0, 16'h0000, 16'hFFFF, 16'd0, 1'b0, 1'b0);
      run_txn(1'b1, 16'h0100, 16'h0001, 16'd20, 1'b1, 1'b0);
      run_txn(1'b1, 16'h00AA, 16'h0F0F, 16'd0, 1'b0, 1'b0);
      run_txn(1'b0, 16'hBEEF, 16'h1111, 16'd0, 1'b1, 1'b1);

      // Abort in the third load high phase.
      done_kill = 1'b0;
      @(negedge clk);
      mode_in = 1'b0; op_a = 16'h5555; op_b = 16'h2222; clock_sel_in = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      rises = 0; ps_a = 1'b0;
      for (guard = 0; guard < 500; guard++) begin
         @(negedge clk);
         if (w_shift && !ps_a) rises++;
         ps_a = w_shift;
         if (rises == 3) break;
      end
      check_eq("abort_reached_hi", 32'(rises), 32'd3);
      #2 rst_n = 1'b0;
      #1 check_eq("abort_async_reset", {w_din, w_shift, w_stop, w_mode, w_clock_sel, w_rst_n,
                                        busy, valid, result, timeout_err}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("abort_wrst_n_release", 32'(w_rst_n), 32'd1);
      vcount = 0;
      repeat (20) begin
         @(negedge clk);
         if (valid || busy) vcount++;
      end
      check_eq("abort_no_valid", 32'(vcount), 32'd0);
      run_txn(1'b0, 16'h0002, 16'h0003, 16'd0, 1'b0, 1'b0);

      for (int i = 0; i < 10; i++) begin
         m_r  = 1'($urandom_range(0, 1));
         cs_r = 1'($urandom_range(0, 1));
         a_r  = 16'($urandom);
         b_r  = 16'($urandom);
         sa_r = 16'($urandom_range(0, 60));
         run_txn(m_r, a_r, b_r, sa_r, cs_r, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
